sm_bus_snoop: RTL and testbench
===============================

// Module: sm_bus_snoop
// PURPOSE
//  Bus-side (snoop) MSI controller; partner to the CPU-side FSM. Holds per-line state/tag for a direct-mapped cache,
//  answers read-miss/write-miss/invalidate messages from other caches, sequences the write-back of Modified lines
//  and downgrades/invalidates local copies. Sits between the shared snoop bus and the memory write-back port.
// PARAMETERS
//  LINES  4  number of cache lines (power of 2)
//  IDX_W  2  index width, log2(LINES)
//  TAG_W  4  tag width
// PORTS
//  clock           in   1      single clock, all logic on posedge
//  reset           in   1      synchronous, active-high
//  bus_valid       in   1      snoop message present
//  bus_ready       out  1      1 = message accepted this edge (handshake: valid & ready)
//  bus_op          in   2      01 readMiss, 10 writeMiss, 11 invalidate, 00 no-op
//  bus_index       in   IDX_W  line index of message
//  bus_tag         in   TAG_W  tag of message
//  writeBack       out  1      write-back request to memory, held until mem_ack
//  abortMemoryAccess out 1     tells memory to cancel its reply; asserted with writeBack
//  wb_index        out  IDX_W  line being written back
//  wb_tag          out  TAG_W  tag being written back
//  mem_ack         in   1      memory completed write-back
//  snoop_done      out  1      1-cycle pulse: message fully handled
//  snoop_hit       out  1      valid with snoop_done: tag matched a non-Invalid line
//  cpu_upd_valid   in   1      CPU side writes a line entry this edge
//  cpu_upd_index   in   IDX_W  entry index
//  cpu_upd_tag     in   TAG_W  new tag
//  cpu_upd_state   in   2      new state: 00 Invalid, 01 Shared, 10 Modified
//  cpu_upd_conflict out 1      1-cycle pulse: CPU update dropped (collision)
//  cpu_rd_index    in   IDX_W  combinational read port index
//  cpu_rd_state    out  2      state of cpu_rd_index
//  cpu_rd_tag      out  TAG_W  tag of cpu_rd_index
// BEHAVIOUR
//  - Reset: all lines Invalid, tags 0, FSM IDLE; all outputs 0 except bus_ready=1 on the cycle after reset. Reset
//    mid-write-back drops writeBack/abortMemoryAccess next edge; in-flight message lost, no snoop_done.
//  - FSM IDLE: bus_ready=1; on valid&ready capture op/index/tag -> LOOKUP. LOOKUP, WRITEBACK: bus_ready=0.
//  - LOOKUP (1 cycle): hit = tag[idx]==tag & state!=Invalid. Uses table contents incl. CPU updates from prior edges.
//    * no-op or miss: line unchanged; snoop_done=1, snoop_hit=0 next cycle; -> IDLE.
//    * Shared hit: readMiss keeps Shared; writeMiss/invalidate -> Invalid; done+hit next cycle; -> IDLE.
//    * Modified hit, readMiss or writeMiss: -> WRITEBACK; writeBack=abortMemoryAccess=1, wb_index/wb_tag latched.
//  - WRITEBACK: outputs held stable until mem_ack sampled 1; on that edge line -> Shared (readMiss) or Invalid
//    (writeMiss), outputs drop, snoop_done+hit pulse next cycle, -> IDLE. No timeout.
//  - Latency: accept edge E0; non-write-back done at cycle after E1 (2 cycles); write-back = 2 + ack wait.
//  - Throughput: next message accepted the cycle snoop_done pulses (bus_ready=1 in IDLE).
//  - CPU update: applied on any edge; if same edge commits a snoop state change to the same index, snoop wins,
//    CPU write dropped, cpu_upd_conflict pulses. CPU update to an index in WRITEBACK is also dropped + conflict.
//  - cpu_upd_state=11 is ignored (no write, no conflict). bus_op/bus_tag unused bits never alter table.
// CONFIGURATION
//  SNOOP_PROTO_ERR_EN defined: extra output protocol_err (1 bit, sticky, cleared only by reset); invalidate hitting
//    a Modified line sets it, line -> Invalid with no write-back, done+hit next cycle.
//  Not defined: no protocol_err port; invalidate on Modified treated exactly as writeMiss (write-back, -> Invalid).
// TESTING
//  1 reset, cpu_upd idx1 tag5 Shared; bus readMiss idx1 tag5 -> done+hit 2 cycles later, state stays 01.
//  2 idx2 tag3 Modified; bus writeMiss idx2 tag3; mem_ack after 4 cycles -> writeBack/abort held 1..ack,
//    wb_index=2 wb_tag=3, then state 00, done+hit.
//  3 idx0 tag7 Shared; bus invalidate idx0 tag6 -> done, hit=0, state stays 01 tag7.
//  4 idx3 tag1 Modified; bus readMiss idx3 tag1 with cpu_upd idx3 Modified during WRITEBACK -> conflict pulse;
//    after ack state 01.
//  5 reset asserted while writeBack=1 -> next edge writeBack=0, all lines 00, no snoop_done.
//  6 macro on: idx2 Modified, bus invalidate idx2 -> protocol_err=1 sticky, writeBack never 1, state 00.

Source files
------------

// File: rtl/sm_bus_snoop.sv
// ---------------------------------------------------------------------------
// sm_bus_snoop
//   Bus-side (snoop) MSI controller for a direct-mapped cache. It holds the
//   per-line state and tag, answers readMiss / writeMiss / invalidate messages
//   from other caches, sequences the write-back of Modified lines and
//   downgrades or invalidates local copies.
//
//   Optional feature macro: SNOOP_PROTO_ERR_EN
//     defined   : adds the sticky output protocol_err. An invalidate that hits
//                 a Modified line sets it, and the line goes Invalid without a
//                 write-back.
//     undefined : an invalidate that hits a Modified line behaves exactly like
//                 a writeMiss (write-back, then Invalid).
//
// Ports
//   clock, reset            single clock; synchronous active-high reset
//   bus_valid/bus_ready     snoop message handshake (accepted on valid & ready)
//   bus_op/index/tag        01 readMiss, 10 writeMiss, 11 invalidate, 00 no-op
//   writeBack, abortMemoryAccess, wb_index, wb_tag
//                           write-back request to memory, held until mem_ack
//   mem_ack                 memory has completed the write-back
//   snoop_done, snoop_hit   1-cycle pulse when a message has been fully handled
//   cpu_upd_*               CPU-side line write port; cpu_upd_conflict pulses
//                           when a CPU write is dropped
//   cpu_rd_index/state/tag  combinational read port into the line table
//   protocol_err            only when SNOOP_PROTO_ERR_EN is defined
// ---------------------------------------------------------------------------
module sm_bus_snoop #(
  parameter int LINES = 4,
  parameter int IDX_W = 2,
  parameter int TAG_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             bus_valid,
  output logic             bus_ready,
  input  logic [1:0]       bus_op,
  input  logic [IDX_W-1:0] bus_index,
  input  logic [TAG_W-1:0] bus_tag,
  output logic             writeBack,
  output logic             abortMemoryAccess,
  output logic [IDX_W-1:0] wb_index,
  output logic [TAG_W-1:0] wb_tag,
  input  logic             mem_ack,
  output logic             snoop_done,
  output logic             snoop_hit,
  input  logic             cpu_upd_valid,
  input  logic [IDX_W-1:0] cpu_upd_index,
  input  logic [TAG_W-1:0] cpu_upd_tag,
  input  logic [1:0]       cpu_upd_state,
  output logic             cpu_upd_conflict,
`ifdef SNOOP_PROTO_ERR_EN
  output logic             protocol_err,
`endif
  input  logic [IDX_W-1:0] cpu_rd_index,
  output logic [1:0]       cpu_rd_state,
  output logic [TAG_W-1:0] cpu_rd_tag
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_WB     = 2'd2
  } fsm_e;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_RD  = 2'b01;
  localparam logic [1:0] OP_INV = 2'b11;

  localparam logic [1:0] LS_INV = 2'b00;
  localparam logic [1:0] LS_SHR = 2'b01;
  localparam logic [1:0] LS_RSV = 2'b11;

  fsm_e             fsm_q, fsm_d;
  logic [1:0]       op_q, op_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic [1:0]       lstate_q [LINES];
  logic [1:0]       lstate_d [LINES];
  logic [TAG_W-1:0] ltag_q   [LINES];
  logic [TAG_W-1:0] ltag_d   [LINES];

  logic             bus_ready_q, bus_ready_d;
  logic             wb_req_q, wb_req_d;
  logic             abort_q, abort_d;
  logic [IDX_W-1:0] wb_index_q, wb_index_d;
  logic [TAG_W-1:0] wb_tag_q, wb_tag_d;
  logic             done_q, done_d;
  logic             hit_q, hit_d;
  logic             conflict_q, conflict_d;
`ifdef SNOOP_PROTO_ERR_EN
  logic             perr_q, perr_d;
`endif

  // Snoop-side commit to the line table on this edge (always at idx_q).
  logic             snoop_wr_s;
  logic [1:0]       snoop_state_s;
  logic             lookup_hit_s;

  // A no-op never hits even when the tag matches; the no-op check is applied
  // in the LOOKUP branch, so this is purely the table match.
  assign lookup_hit_s = (ltag_q[idx_q] == tag_q) && (lstate_q[idx_q] != LS_INV);

  // Next-state, table update and output computation.
  always_comb begin
    fsm_d         = fsm_q;
    op_d          = op_q;
    idx_d         = idx_q;
    tag_d         = tag_q;
    lstate_d      = lstate_q;
    ltag_d        = ltag_q;
    wb_req_d      = wb_req_q;
    abort_d       = abort_q;
    wb_index_d    = wb_index_q;
    wb_tag_d      = wb_tag_q;
    done_d        = 1'b0;
    hit_d         = 1'b0;
    conflict_d    = 1'b0;
    snoop_wr_s    = 1'b0;
    snoop_state_s = LS_INV;
`ifdef SNOOP_PROTO_ERR_EN
    perr_d        = perr_q;
`endif

    case (fsm_q)
      ST_IDLE: begin
        if (bus_valid && bus_ready_q) begin
          op_d  = bus_op;
          idx_d = bus_index;
          tag_d = bus_tag;
          fsm_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if ((op_q == OP_NOP) || !lookup_hit_s) begin
          done_d = 1'b1;
          fsm_d  = ST_IDLE;
        end else if (lstate_q[idx_q] == LS_SHR) begin
          // readMiss leaves a Shared copy alone; anything else kills it.
          done_d = 1'b1;
          hit_d  = 1'b1;
          fsm_d  = ST_IDLE;
          if (op_q != OP_RD) begin
            snoop_wr_s = 1'b1;
          end
        end
`ifdef SNOOP_PROTO_ERR_EN
        else if (op_q == OP_INV) begin
          // Another cache claims exclusivity of a line we hold dirty: flag it
          // and drop our copy without writing it back.
          snoop_wr_s = 1'b1;
          perr_d     = 1'b1;
          done_d     = 1'b1;
          hit_d      = 1'b1;
          fsm_d      = ST_IDLE;
        end
`endif
        else begin
          // Modified hit: the dirty data must reach memory first.
          fsm_d      = ST_WB;
          wb_req_d   = 1'b1;
          abort_d    = 1'b1;
          wb_index_d = idx_q;
          wb_tag_d   = tag_q;
        end
      end
      ST_WB: begin
        if (mem_ack) begin
          snoop_wr_s    = 1'b1;
          snoop_state_s = (op_q == OP_RD) ? LS_SHR : LS_INV;
          wb_req_d      = 1'b0;
          abort_d       = 1'b0;
          done_d        = 1'b1;
          hit_d         = 1'b1;
          fsm_d         = ST_IDLE;
        end
      end
      default: begin
        fsm_d = ST_IDLE;
      end
    endcase

    if (snoop_wr_s) begin
      lstate_d[idx_q] = snoop_state_s;
    end

    // CPU writes lose to a same-edge snoop commit and are locked out of a line
    // that is being written back.
    if (cpu_upd_valid && (cpu_upd_state != LS_RSV)) begin
      if ((idx_q == cpu_upd_index) && (snoop_wr_s || (fsm_q == ST_WB))) begin
        conflict_d = 1'b1;
      end else begin
        lstate_d[cpu_upd_index] = cpu_upd_state;
        ltag_d[cpu_upd_index]   = cpu_upd_tag;
      end
    end

    bus_ready_d = (fsm_d == ST_IDLE);
  end

  // State, line table and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      fsm_q       <= ST_IDLE;
      op_q        <= 2'b00;
      idx_q       <= '0;
      tag_q       <= '0;
      for (int i = 0; i < LINES; i++) begin
        lstate_q[i] <= LS_INV;
        ltag_q[i]   <= '0;
      end
      bus_ready_q <= 1'b1;
      wb_req_q    <= 1'b0;
      abort_q     <= 1'b0;
      wb_index_q  <= '0;
      wb_tag_q    <= '0;
      done_q      <= 1'b0;
      hit_q       <= 1'b0;
      conflict_q  <= 1'b0;
`ifdef SNOOP_PROTO_ERR_EN
      perr_q      <= 1'b0;
`endif
    end else begin
      fsm_q       <= fsm_d;
      op_q        <= op_d;
      idx_q       <= idx_d;
      tag_q       <= tag_d;
      lstate_q    <= lstate_d;
      ltag_q      <= ltag_d;
      bus_ready_q <= bus_ready_d;
      wb_req_q    <= wb_req_d;
      abort_q     <= abort_d;
      wb_index_q  <= wb_index_d;
      wb_tag_q    <= wb_tag_d;
      done_q      <= done_d;
      hit_q       <= hit_d;
      conflict_q  <= conflict_d;
`ifdef SNOOP_PROTO_ERR_EN
      perr_q      <= perr_d;
`endif
    end
  end

  assign bus_ready         = bus_ready_q;
  assign writeBack         = wb_req_q;
  assign abortMemoryAccess = abort_q;
  assign wb_index          = wb_index_q;
  assign wb_tag            = wb_tag_q;
  assign snoop_done        = done_q;
  assign snoop_hit         = hit_q;
  assign cpu_upd_conflict  = conflict_q;
`ifdef SNOOP_PROTO_ERR_EN
  assign protocol_err      = perr_q;
`endif
  assign cpu_rd_state      = lstate_q[cpu_rd_index];
  assign cpu_rd_tag        = ltag_q[cpu_rd_index];

endmodule

// File: tb/tb_sm_bus_snoop.sv
// ---------------------------------------------------------------------------
// tb_sm_bus_snoop
//   Self-checking bench for sm_bus_snoop: directed scenarios followed by
//   random traffic, every cycle compared against a message-level MSI model.
//   Build with SNOOP_PROTO_ERR_EN defined to cover the protocol_err variant.
// ---------------------------------------------------------------------------
module tb_sm_bus_snoop;

  logic       clock;
  logic       reset;
  logic       bus_valid;
  logic       bus_ready;
  logic [1:0] bus_op;
  logic [1:0] bus_index;
  logic [3:0] bus_tag;
  logic       writeBack;
  logic       abortMemoryAccess;
  logic [1:0] wb_index;
  logic [3:0] wb_tag;
  logic       mem_ack;
  logic       snoop_done;
  logic       snoop_hit;
  logic       cpu_upd_valid;
  logic [1:0] cpu_upd_index;
  logic [3:0] cpu_upd_tag;
  logic [1:0] cpu_upd_state;
  logic       cpu_upd_conflict;
  logic [1:0] cpu_rd_index;
  logic [1:0] cpu_rd_state;
  logic [3:0] cpu_rd_tag;
`ifdef SNOOP_PROTO_ERR_EN
  logic       protocol_err;
`endif

  sm_bus_snoop #(.LINES(4), .IDX_W(2), .TAG_W(4)) dut (
    .clock(clock), .reset(reset),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_op(bus_op),
    .bus_index(bus_index), .bus_tag(bus_tag),
    .writeBack(writeBack), .abortMemoryAccess(abortMemoryAccess),
    .wb_index(wb_index), .wb_tag(wb_tag), .mem_ack(mem_ack),
    .snoop_done(snoop_done), .snoop_hit(snoop_hit),
    .cpu_upd_valid(cpu_upd_valid), .cpu_upd_index(cpu_upd_index),
    .cpu_upd_tag(cpu_upd_tag), .cpu_upd_state(cpu_upd_state),
    .cpu_upd_conflict(cpu_upd_conflict),
`ifdef SNOOP_PROTO_ERR_EN
    .protocol_err(protocol_err),
`endif
    .cpu_rd_index(cpu_rd_index), .cpu_rd_state(cpu_rd_state), .cpu_rd_tag(cpu_rd_tag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Single comparison point for the whole bench.
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Line table plus the message in flight. Phase: 0 waiting for a message,
  // 1 message accepted (lookup pending), 2 waiting for memory ack.
  logic [1:0] m_st  [4];
  logic [3:0] m_tg  [4];
  int         m_phase;
  logic [1:0] m_op;
  logic [1:0] m_idx;
  logic [3:0] m_tag;
  bit         m_known = 1'b0;

  logic       e_ready, e_wb, e_done, e_hit, e_conf, e_perr;
  logic [1:0] e_wbidx;
  logic [3:0] e_wbtag;

  typedef struct packed {
    logic       hit;
    logic       chg;
    logic [1:0] nst;
    logic       wb;
    logic       perr;
  } outcome_t;

  // MSI response of a snooped message against one line.
  function automatic outcome_t decide(input logic [1:0] op, input logic [1:0] st, input logic tag_eq);
    outcome_t o;
    o = '0;
    o.nst = st;
    if (op != 2'b00 && st != 2'b00 && tag_eq) begin
      o.hit = 1'b1;
      if (st == 2'b01) begin
        if (op != 2'b01) begin
          o.chg = 1'b1;
          o.nst = 2'b00;
        end
      end else begin
`ifdef SNOOP_PROTO_ERR_EN
        if (op == 2'b11) begin
          o.chg  = 1'b1;
          o.nst  = 2'b00;
          o.perr = 1'b1;
        end else begin
          o.wb = 1'b1;
        end
`else
        o.wb = 1'b1;
`endif
      end
    end
    return o;
  endfunction

  // Advance the model across one clock edge using the currently driven inputs.
  task automatic model_edge();
    int       old_phase;
    bit       sw;
    logic [1:0] sw_st;
    outcome_t o;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        m_st[i] = 2'b00;
        m_tg[i] = 4'd0;
      end
      m_phase = 0;
      e_ready = 1'b1; e_wb = 1'b0; e_done = 1'b0; e_hit = 1'b0;
      e_conf = 1'b0; e_perr = 1'b0;
      m_known = 1'b1;
      return;
    end
    old_phase = m_phase;
    sw = 1'b0;
    sw_st = 2'b00;
    e_done = 1'b0; e_hit = 1'b0; e_conf = 1'b0;
    if (old_phase == 0) begin
      if (bus_valid) begin
        m_op = bus_op; m_idx = bus_index; m_tag = bus_tag;
        m_phase = 1;
      end
    end else if (old_phase == 1) begin
      o = decide(m_op, m_st[m_idx], m_tg[m_idx] == m_tag);
      if (o.wb) begin
        m_phase = 2;
        e_wb = 1'b1; e_wbidx = m_idx; e_wbtag = m_tag;
      end else begin
        m_phase = 0;
        e_done = 1'b1; e_hit = o.hit;
        sw = o.chg; sw_st = o.nst;
        if (o.perr) e_perr = 1'b1;
      end
    end else begin
      if (mem_ack) begin
        sw = 1'b1;
        sw_st = (m_op == 2'b01) ? 2'b01 : 2'b00;
        e_wb = 1'b0;
        e_done = 1'b1; e_hit = 1'b1;
        m_phase = 0;
      end
    end
    if (cpu_upd_valid && cpu_upd_state != 2'b11) begin
      if ((sw || old_phase == 2) && cpu_upd_index == m_idx) begin
        e_conf = 1'b1;
      end else begin
        m_st[cpu_upd_index] = cpu_upd_state;
        m_tg[cpu_upd_index] = cpu_upd_tag;
      end
    end
    if (sw) m_st[m_idx] = sw_st;
    e_ready = (m_phase == 0);
  endtask

  // One clock: read-port check, model step, edge, registered-output checks.
  task automatic run_cycle();
    #4;
    if (m_known) begin
      check_val("rd_state", cpu_rd_state, m_st[cpu_rd_index]);
      check_val("rd_tag", cpu_rd_tag, m_tg[cpu_rd_index]);
    end
    model_edge();
    @(posedge clock);
    #1;
    check_val("bus_ready", bus_ready, e_ready);
    check_val("writeBack", writeBack, e_wb);
    check_val("abort", abortMemoryAccess, e_wb);
    check_val("snoop_done", snoop_done, e_done);
    check_val("snoop_hit", snoop_hit, e_hit);
    check_val("conflict", cpu_upd_conflict, e_conf);
    if (e_wb) begin
      check_val("wb_index", wb_index, e_wbidx);
      check_val("wb_tag", wb_tag, e_wbtag);
    end
`ifdef SNOOP_PROTO_ERR_EN
    check_val("protocol_err", protocol_err, e_perr);
`endif
  endtask

  task automatic drive_idle();
    reset = 1'b0; bus_valid = 1'b0; bus_op = 2'b00; bus_index = 2'd0; bus_tag = 4'd0;
    mem_ack = 1'b0; cpu_upd_valid = 1'b0; cpu_upd_index = 2'd0; cpu_upd_tag = 4'd0;
    cpu_upd_state = 2'b00; cpu_rd_index = 2'($urandom_range(0, 3));
  endtask

  task automatic cpu_write(input logic [1:0] idx, input logic [3:0] tg, input logic [1:0] st);
    drive_idle();
    cpu_upd_valid = 1'b1; cpu_upd_index = idx; cpu_upd_tag = tg; cpu_upd_state = st;
    run_cycle();
  endtask

  task automatic bus_msg(input logic [1:0] op, input logic [1:0] idx, input logic [3:0] tg);
    drive_idle();
    bus_valid = 1'b1; bus_op = op; bus_index = idx; bus_tag = tg;
    run_cycle();
    drive_idle();
  endtask

  task automatic peek(input logic [1:0] idx, input string tag, input logic [1:0] st, input logic [3:0] tg);
    cpu_rd_index = idx;
    #1;
    check_val({tag, "_state"}, cpu_rd_state, st);
    check_val({tag, "_tag"}, cpu_rd_tag, tg);
  endtask

  initial begin
    drive_idle();
    reset = 1'b1;
    run_cycle();
    run_cycle();
    drive_idle();
    check_val("reset_ready", bus_ready, 1'b1);
    check_val("reset_done", snoop_done, 1'b0);

    // 1: Shared hit by readMiss keeps Shared.
    cpu_write(2'd1, 4'd5, 2'b01);
    bus_msg(2'b01, 2'd1, 4'd5);
    run_cycle();
    check_val("t1_done", snoop_done, 1'b1);
    check_val("t1_hit", snoop_hit, 1'b1);
    peek(2'd1, "t1", 2'b01, 4'd5);

    // 2: Modified hit by writeMiss, ack after 4 cycles of write-back.
    cpu_write(2'd2, 4'd3, 2'b10);
    bus_msg(2'b10, 2'd2, 4'd3);
    run_cycle();
    for (int i = 0; i < 4; i++) begin
      check_val("t2_wb", writeBack, 1'b1);
      check_val("t2_abort", abortMemoryAccess, 1'b1);
      check_val("t2_wbidx", wb_index, 2'd2);
      check_val("t2_wbtag", wb_tag, 4'd3);
      if (i < 3) run_cycle();
    end
    mem_ack = 1'b1;
    run_cycle();
    drive_idle();
    check_val("t2_done", snoop_done, 1'b1);
    check_val("t2_hit", snoop_hit, 1'b1);
    check_val("t2_wb_off", writeBack, 1'b0);
    peek(2'd2, "t2", 2'b00, 4'd3);

    // 3: invalidate with mismatching tag is a miss.
    cpu_write(2'd0, 4'd7, 2'b01);
    bus_msg(2'b11, 2'd0, 4'd6);
    run_cycle();
    check_val("t3_done", snoop_done, 1'b1);
    check_val("t3_hit", snoop_hit, 1'b0);
    peek(2'd0, "t3", 2'b01, 4'd7);

    // 4: CPU update to the line under write-back is dropped.
    cpu_write(2'd3, 4'd1, 2'b10);
    bus_msg(2'b01, 2'd3, 4'd1);
    run_cycle();
    cpu_upd_valid = 1'b1; cpu_upd_index = 2'd3; cpu_upd_tag = 4'd9; cpu_upd_state = 2'b10;
    run_cycle();
    drive_idle();
    check_val("t4_conflict", cpu_upd_conflict, 1'b1);
    mem_ack = 1'b1;
    run_cycle();
    drive_idle();
    check_val("t4_done", snoop_done, 1'b1);
    peek(2'd3, "t4", 2'b01, 4'd1);

    // 5: reset in the middle of a write-back.
    cpu_write(2'd1, 4'd2, 2'b10);
    bus_msg(2'b10, 2'd1, 4'd2);
    run_cycle();
    check_val("t5_wb_on", writeBack, 1'b1);
    reset = 1'b1;
    run_cycle();
    drive_idle();
    check_val("t5_wb_off", writeBack, 1'b0);
    check_val("t5_done", snoop_done, 1'b0);
    for (int i = 0; i < 4; i++) begin
      peek(2'(i), "t5", 2'b00, 4'd0);
    end
    run_cycle();
    check_val("t5_no_done", snoop_done, 1'b0);

`ifdef SNOOP_PROTO_ERR_EN
    // 6: invalidate hitting Modified raises the sticky error, no write-back.
    cpu_write(2'd2, 4'd4, 2'b10);
    bus_msg(2'b11, 2'd2, 4'd4);
    run_cycle();
    check_val("t6_perr", protocol_err, 1'b1);
    check_val("t6_wb", writeBack, 1'b0);
    check_val("t6_hit", snoop_hit, 1'b1);
    run_cycle();
    check_val("t6_sticky", protocol_err, 1'b1);
    peek(2'd2, "t6", 2'b00, 4'd4);
`endif

    // Random traffic; small tag range so hits and conflicts are common.
    for (int n = 0; n < 3000; n++) begin
      reset         = ($urandom_range(0, 299) == 0);
      bus_valid     = ($urandom_range(0, 2) == 0);
      bus_op        = 2'($urandom_range(0, 3));
      bus_index     = 2'($urandom_range(0, 3));
      bus_tag       = 4'($urandom_range(0, 3));
      mem_ack       = ($urandom_range(0, 2) == 0);
      cpu_upd_valid = ($urandom_range(0, 1) == 0);
      cpu_upd_index = 2'($urandom_range(0, 3));
      cpu_upd_tag   = 4'($urandom_range(0, 3));
      cpu_upd_state = 2'($urandom_range(0, 3));
      cpu_rd_index  = 2'($urandom_range(0, 3));
      run_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
